// File: rtl/wr_resp_order_queue_if.sv
// Push/pop/status bundle between the AW arbiter, the response order queue and the B demux.
// master drives pushes/pops and control; slave is the queue itself.
interface wr_resp_order_queue_if #(
  parameter int ID_W  = 2,
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ID_W-1:0]  Master_ID;
  logic             Write_Resp_Grant;
  logic             Write_Resp_Finsh;
  logic             Queue_Flush;
  logic             Err_Clear;
  logic [ID_W-1:0]  Resp_Master_ID;
  logic             Resp_Master_Valid;
  logic             Queue_Is_Full;
  logic             Queue_Is_Empty;
  logic             Queue_Almost_Full;
  logic [CNT_W-1:0] Queue_Count;
  logic             Overflow_Err;
  logic             Underflow_Err;

  modport master (
    output Master_ID, Write_Resp_Grant, Write_Resp_Finsh, Queue_Flush, Err_Clear,
    input  Resp_Master_ID, Resp_Master_Valid, Queue_Is_Full, Queue_Is_Empty,
           Queue_Almost_Full, Queue_Count, Overflow_Err, Underflow_Err
  );

  modport slave (
    input  Master_ID, Write_Resp_Grant, Write_Resp_Finsh, Queue_Flush, Err_Clear,
    output Resp_Master_ID, Resp_Master_Valid, Queue_Is_Full, Queue_Is_Empty,
           Queue_Almost_Full, Queue_Count, Overflow_Err, Underflow_Err
  );
endinterface

// File: rtl/wr_resp_order_queue.sv
// Write-response ordering FIFO of granted master IDs; head visible one cycle after push, no bypass.
// Pushes while full are dropped (sticky overflow) unless a pop frees the slot; pops while empty are ignored.
module wr_resp_order_queue #(
  parameter int ID_W     = 2,
  parameter int DEPTH    = 8,
  parameter int AFULL_TH = 6
) (
  input logic                clk,
  input logic                reset,
  wr_resp_order_queue_if.slave q
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AFULL_TH);

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf_err;
  logic             unf_err;

  logic full;
  logic empty;
  logic pop_ok;
  logic push_ok;
  logic ovf_evt;
  logic unf_evt;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = q.Write_Resp_Finsh & ~empty;
  assign push_ok = q.Write_Resp_Grant & (~full | pop_ok);
  // A flush cycle swallows its push/pop attempts, so they cannot raise errors either.
  assign ovf_evt = q.Write_Resp_Grant & full & ~pop_ok & ~q.Queue_Flush;
  assign unf_evt = q.Write_Resp_Finsh & empty & ~q.Queue_Flush;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (q.Queue_Flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
        if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
        if (push_ok && !pop_ok)      count <= count + 1'b1;
        else if (pop_ok && !push_ok) count <= count - 1'b1;
      end
      // Set wins over a coincident clear.
      ovf_err <= ovf_evt | (ovf_err & ~q.Err_Clear);
      unf_err <= unf_evt | (unf_err & ~q.Err_Clear);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !q.Queue_Flush && push_ok) mem[wr_ptr] <= q.Master_ID;
  end

  // Gating with valid keeps the unreset storage from leaking onto the head ID.
  assign q.Resp_Master_Valid = ~empty;
  assign q.Resp_Master_ID    = empty ? '0 : mem[rd_ptr];
  assign q.Queue_Is_Full     = full;
  assign q.Queue_Is_Empty    = empty;
  assign q.Queue_Almost_Full = (count >= AF_CNT);
  assign q.Queue_Count       = count;
  assign q.Overflow_Err      = ovf_err;
  assign q.Underflow_Err     = unf_err;
endmodule

// File: tb/tb_wr_resp_order_queue.sv
// Drives two queue instances (DEPTH 8 and 5) with shared stimulus; scoreboard of expected IDs plus a count/flag model.
module tb_wr_resp_order_queue;
  localparam int ID_W = 2;
  localparam int D0 = 8, A0 = 6;
  localparam int D1 = 5, A1 = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [ID_W-1:0] mid = '0;
  logic grant = 1'b0, finsh = 1'b0, flush = 1'b0, eclr = 1'b0;

  wr_resp_order_queue_if #(.ID_W(ID_W), .DEPTH(D0)) q0 ();
  wr_resp_order_queue_if #(.ID_W(ID_W), .DEPTH(D1)) q1 ();

  assign q0.Master_ID = mid;   assign q1.Master_ID = mid;
  assign q0.Write_Resp_Grant = grant; assign q1.Write_Resp_Grant = grant;
  assign q0.Write_Resp_Finsh = finsh; assign q1.Write_Resp_Finsh = finsh;
  assign q0.Queue_Flush = flush; assign q1.Queue_Flush = flush;
  assign q0.Err_Clear = eclr;  assign q1.Err_Clear = eclr;

  wr_resp_order_queue #(.ID_W(ID_W), .DEPTH(D0), .AFULL_TH(A0)) dut0 (.clk(clk), .reset(reset), .q(q0));
  wr_resp_order_queue #(.ID_W(ID_W), .DEPTH(D1), .AFULL_TH(A1)) dut1 (.clk(clk), .reset(reset), .q(q1));

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference state: what each queue should hold after the most recent edge.
  int dep[2] = '{D0, D1};
  int ath[2] = '{A0, A1};
  int m_cnt[2];
  bit m_ovf[2];
  bit m_unf[2];
  logic [ID_W-1:0] sb0[$];
  logic [ID_W-1:0] sb1[$];

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s depth=%0d t=%0t act=%0d exp=%0d", nm, dep[k], $time, act, exp);
    end
  endtask

  task automatic sb_push(input int k, input logic [ID_W-1:0] id);
    if (k == 0) sb0.push_back(id); else sb1.push_back(id);
  endtask

  task automatic sb_clear(input int k);
    if (k == 0) sb0.delete(); else sb1.delete();
  endtask

  // Apply the inputs held during the last cycle to the model.
  task automatic upd(input int k);
    bit pop_ok, push_ok, ev_o, ev_u;
    if (reset) begin
      m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      sb_clear(k);
    end else begin
      pop_ok  = finsh && (m_cnt[k] > 0);
      push_ok = grant && ((m_cnt[k] < dep[k]) || pop_ok);
      ev_o = !flush && grant && (m_cnt[k] == dep[k]) && !pop_ok;
      ev_u = !flush && finsh && (m_cnt[k] == 0);
      m_ovf[k] = ev_o || (m_ovf[k] && !eclr);
      m_unf[k] = ev_u || (m_unf[k] && !eclr);
      if (flush) begin
        m_cnt[k] = 0;
        sb_clear(k);
      end else begin
        m_cnt[k] = m_cnt[k] + int'(push_ok) - int'(pop_ok);
        if (push_ok) sb_push(k, mid);
      end
    end
  endtask

  task automatic mon(input int k, input int cnt, input bit vld, input bit emp, input bit ful,
                     input bit af, input bit ov, input bit un, input logic [ID_W-1:0] rid);
    logic [ID_W-1:0] exp_id;
    int sz;
    chk("count", k, cnt, m_cnt[k]);
    chk("valid", k, int'(vld), int'(m_cnt[k] != 0));
    chk("empty", k, int'(emp), int'(m_cnt[k] == 0));
    chk("full", k, int'(ful), int'(m_cnt[k] == dep[k]));
    chk("afull", k, int'(af), int'(m_cnt[k] >= ath[k]));
    chk("ovf_err", k, int'(ov), int'(m_ovf[k]));
    chk("unf_err", k, int'(un), int'(m_unf[k]));
    sz = (k == 0) ? sb0.size() : sb1.size();
    if (m_cnt[k] > 0) begin
      if (sz == 0) begin
        chk("sb_nonempty", k, 0, 1);
      end else begin
        exp_id = (k == 0) ? sb0[0] : sb1[0];
        chk("head_id", k, int'(rid), int'(exp_id));
        // A B handshake completes on the coming edge: retire the expected head.
        if (finsh && !flush && !reset) begin
          if (k == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      mon(0, int'(q0.Queue_Count), q0.Resp_Master_Valid, q0.Queue_Is_Empty, q0.Queue_Is_Full,
          q0.Queue_Almost_Full, q0.Overflow_Err, q0.Underflow_Err, q0.Resp_Master_ID);
      mon(1, int'(q1.Queue_Count), q1.Resp_Master_Valid, q1.Queue_Is_Empty, q1.Queue_Is_Full,
          q1.Queue_Almost_Full, q1.Overflow_Err, q1.Underflow_Err, q1.Resp_Master_ID);
    end
  end

  task automatic cyc(input bit g, input bit f, input logic [ID_W-1:0] id,
                     input bit fl = 1'b0, input bit ec = 1'b0, input bit rs = 1'b0);
    @(posedge clk);
    #1;
    upd(0);
    upd(1);
    chk_en = 1'b1;
    grant = g; finsh = f; mid = id; flush = fl; eclr = ec; reset = rs;
  endtask

  initial begin
    logic [ID_W-1:0] id;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    repeat (5) cyc(0, 0, 0);
    // Ordered push/pop of 3,1,2.
    cyc(1, 0, 2'd3); cyc(1, 0, 2'd1); cyc(1, 0, 2'd2);
    repeat (3) cyc(0, 1, 0);
    cyc(0, 0, 0);
    // Fill past capacity, then push+pop while full.
    for (int i = 0; i < 9; i++) begin
      id = ID_W'(i % 4);
      cyc(1, 0, id);
    end
    cyc(0, 0, 0);
    cyc(1, 1, 2'd1);
    cyc(0, 0, 0, 0, 1);
    repeat (9) cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0);
    // Underflow with a concurrent push, then error clear coinciding with an underflow.
    cyc(1, 1, 2'd2);
    cyc(0, 1, 0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0);
    // Four entries then flush with simultaneous push.
    for (int i = 0; i < 4; i++) begin
      id = ID_W'(i);
      cyc(1, 0, id);
    end
    cyc(1, 1, 2'd2, 1);
    cyc(0, 0, 0);
    // Pointer wrap: keep two in flight while cycling IDs.
    cyc(1, 0, 2'd0); cyc(1, 0, 2'd1);
    for (int i = 0; i < 12; i++) begin
      id = ID_W'(i % 4);
      cyc(1, 1, id);
    end
    repeat (3) cyc(0, 1, 0);
    // Randomized phase with rare flush, clear and reset.
    for (int i = 0; i < 3000; i++) begin
      id = ID_W'($urandom_range(0, (1 << ID_W) - 1));
      cyc(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), id,
          ($urandom_range(0, 79) == 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 699) == 0));
    end
    cyc(0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wr_resp_order_queue.md
Name: wr_resp_order_queue

Overview:
- Parametrised write-response ordering queue for the AXI4 interconnect.
- Records the master ID of each granted write address in grant order. Presents the oldest ID to the B-channel router until that response completes.
- Generalises the fixed single-slot-ID response queue with configurable depth, ID width, occupancy/almost-full status, flush, and sticky error flags.
- Sits between the AW arbiter (push side) and the B-response demux (pop side) of each slave port.

Parameters:
- ID_W, 2, width of master ID field (>=1).
- DEPTH, 8, number of entries (>=2, need not be a power of two).
- AFULL_TH, 6, occupancy at or above which Queue_Almost_Full asserts (1..DEPTH).
- CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- Master_ID  in  ID_W  ID of master whose AW was granted.
- Write_Resp_Grant  in  1  push request: enqueue Master_ID.
- Write_Resp_Finsh  in  1  pop request: B handshake for head entry completed.
- Queue_Flush  in  1  synchronous clear of all entries; error flags are kept.
- Err_Clear  in  1  clears sticky error flags.
- Resp_Master_ID  out  ID_W  ID at queue head.
- Resp_Master_Valid  out  1  queue non-empty; Resp_Master_ID meaningful.
- Queue_Is_Full  out  1  occupancy == DEPTH.
- Queue_Is_Empty  out  1  occupancy == 0.
- Queue_Almost_Full  out  1  occupancy >= AFULL_TH.
- Queue_Count  out  CNT_W  current occupancy.
- Overflow_Err  out  1  sticky: push attempted while full and no concurrent pop.
- Underflow_Err  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset and clock:
  - Reset is sampled on the rising clk edge.
  - Reset values: wr_ptr=0, rd_ptr=0, count=0, Resp_Master_Valid=0, Queue_Is_Empty=1, Queue_Is_Full=0, Queue_Almost_Full=0, Queue_Count=0, Overflow_Err=0, Underflow_Err=0.
  - Resp_Master_ID resets to 0.
  - Storage array contents are not reset.
- Push/pop qualification:
  - push_ok = Write_Resp_Grant & (!full | pop_ok).
  - pop_ok = Write_Resp_Finsh & !empty.
- Storage and pointers:
  - push_ok writes Master_ID to entry wr_ptr. wr_ptr increments, wrapping DEPTH-1 -> 0.
  - pop_ok increments rd_ptr with the same wrap rule.
- Count update:
  - count += push_ok - pop_ok.
  - Push and pop together leave count unchanged.
  - Push and pop together while full is legal: the head is removed and the new ID is written into the freed slot ordering-wise.
- Outputs:
  - All status outputs are registered, or decoded combinationally from registered count only. None depends combinationally on current-cycle inputs.
  - Resp_Master_ID = mem[rd_ptr] (registered pointer), valid only when Resp_Master_Valid=1.
- Latency:
  - A push into an empty queue makes Resp_Master_Valid=1 and Resp_Master_ID=pushed ID in the cycle after the push edge.
  - There is no same-cycle bypass.
- Pop semantics:
  - After pop, the next head appears the following cycle.
  - If the queue becomes empty, Resp_Master_Valid drops the following cycle.
- Overflow:
  - Write_Resp_Grant while full and no pop_ok: push dropped, state unchanged, Overflow_Err set next cycle.
- Underflow:
  - Write_Resp_Finsh while empty: ignored, Underflow_Err set next cycle.
  - This also applies when a push occurs in the same cycle, because the pop is not qualified.
- Flush:
  - Queue_Flush zeroes wr_ptr, rd_ptr and count next cycle.
  - Pushes and pops in the flush cycle are discarded and do not set error flags.
- Error flags:
  - Err_Clear clears both flags next cycle.
  - If an error event and Err_Clear coincide, the flag is set (set wins).
- Priority: reset > Queue_Flush > push/pop.
- Reset mid-operation: all in-flight state is lost and the queue returns to the empty reset values on the next edge.
- Ordering: strict FIFO; IDs are never reordered or duplicated.

Test Plan:
- Reset then idle 5 cycles -> Queue_Is_Empty=1, Resp_Master_Valid=0, Queue_Count=0, both error flags 0.
- Push IDs 3,1,2 on consecutive cycles (DEPTH=8), then pop 3 times:
  - Resp_Master_ID sequence is 3,1,2; Queue_Count goes 1,2,3 then 2,1,0.
  - Valid first high one cycle after the first push.
- Fill to 8:
  - Queue_Is_Full=1; Queue_Almost_Full=1 from count 6.
  - A 9th push without pop -> dropped, Overflow_Err=1, count stays 8, head unchanged.
- While full, push ID 1 and pop together -> count stays 8, no Overflow_Err, the popped head is replaced in order and ID 1 emerges last.
- DEPTH=5: 12 push/pop pairs with IDs 0..3 cycling -> pointers wrap past index 4 correctly and output order matches input order.
- Flush and error clear:
  - Pop on empty -> Underflow_Err=1. Err_Clear -> 0 next cycle.
  - With 4 entries, Queue_Flush plus a simultaneous push -> count=0, no error, valid=0 next cycle.
